mesm6_alu_seq: RTL and testbench
================================

Name: mesm6_alu_seq

Overview:
- Initiator side of the ALU op/done handshake. Accepts one arithmetic-logic command at a time from the control unit and drives `ALU_*` micro-ops onto the ALU (a, b, op).
- Waits for done, captures result and y, and returns op to `ALU_NOP` between micro-ops so the ALU's sticky done and step count clear.
- Chains multi-uop commands (ACX = `ALU_COUNT` then `ALU_ADD_CARRY_AROUND`) and returns the final result over a valid/ready response port.

Parameters:
- TIMEOUT, 15, cycles in RUN without alu_done before abort (used only with watchdog macro).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_code  in  3  0 AAX, 1 AOX, 2 AEX, 3 ARX, 4 ASX, 5 ASN, 6 ACX, 7 illegal
- cmd_acc  in  48  accumulator operand
- cmd_x  in  48  X operand
- cmd_imm  in  7  ASN shift control: bit6 direction, bits5:0 amount
- alu_a  out  48  ALU operand A
- alu_b  out  48  ALU operand B
- alu_op  out  `ALU_OP_WIDTH  ALU micro-op
- alu_result  in  48  ALU result
- alu_y  in  48  ALU low-order result
- alu_done  in  1  ALU op finished (sticky while op != NOP)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_result  out  48  final accumulator
- rsp_y  out  48  final Y
- rsp_err  out  1  illegal command or timeout

Behaviour:
- Reset (async, reset_n low): state IDLE; alu_op=`ALU_NOP`; alu_a, alu_b, rsp_result, rsp_y = 0; rsp_valid=0; rsp_err=0. Takes effect immediately, also mid-operation. The ALU has no reset; the NOP driven from reset clears it on its next clock.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch operands and code.
    - Legal code -> RUN, step 0.
    - Code 7 -> RESP with result=acc, y=0, err=1.
  - RUN: drive alu_op, alu_a, alu_b for the current step. On alu_done, capture alu_result and alu_y -> GAP.
  - GAP: exactly one cycle with alu_op=`ALU_NOP`. Then the next step -> RUN, or RESP if this was the last step.
  - RESP: rsp_valid=1 with outputs stable until rsp_ready. On handshake -> IDLE.
- Step mapping:
  - AAX/AOX/AEX/ARX: op AND/OR/XOR/ADD_CARRY_AROUND, a=acc, b=x.
  - ASX: op SHIFT, a=acc, b=x.
  - ASN: op SHIFT, a=acc, b={cmd_imm,41'b0}.
  - ACX step0: op COUNT, a=acc. ACX step1: op ADD_CARRY_AROUND, a=step0 result, b=x.
- Latency from the accepting edge to rsp_valid high:
  - One-cycle ops: 3 cycles.
  - ARX: 4 cycles.
  - ACX: 7 cycles.
- alu_op is never changed while in RUN before done is seen. The NOP gap is mandatory between any two non-NOP ops.
- rsp_ready held high in IDLE/RUN/GAP has no effect. No new command is accepted in the cycle of the response handshake; cmd_ready rises the following cycle.

Optional Feature:
- Macro: MESM6_ALU_SEQ_WATCHDOG_EN.
- Enabled:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT with alu_done low: -> GAP -> RESP, with rsp_result=0, rsp_y=0, rsp_err=1.
  - Remaining ACX steps are skipped.
- Disabled: RUN waits indefinitely; rsp_err is set only by illegal code 7.

Decomposition:
- mesm6_defines.sv gains `SEQ_CMD_AAX..`SEQ_CMD_ACX and the state encodings. ALU op codes are reused from the same file.
- One natural sub-module: mesm6_alu_watchdog (counter, clear/enable inputs, expired output), instantiated only under the macro.

Test Plan:
- AAX acc=48'hFF00FF, x=48'h0F0F0F -> rsp_result=48'h0F000F, rsp_y=0, rsp_valid 3 cycles after accept; alu_op=NOP in the GAP cycle.
- ARX acc=48'hFFFF_FFFF_FFFF, x=1 -> rsp_result=1 (end-around carry), rsp_y=0, latency 4.
- ACX acc=48'h0FF, x=5 -> rsp_result=13. alu_op sequence is COUNT, NOP, ADD_CARRY_AROUND (2 cycles before done), NOP; latency 7.
- AEX acc=5, x=3 with rsp_ready low for 5 cycles -> rsp_valid, rsp_result=6, rsp_y=5 held stable; cmd_ready=0 until the cycle after the handshake.
- reset_n pulsed low during ARX RUN -> alu_op=NOP and rsp_valid=0 asynchronously. After release, ASN acc=1, imm=7'h01 (left shift by 1) -> rsp_result=2.
- Watchdog enabled, ALU stub with alu_done tied 0, TIMEOUT=15 -> rsp_err=1, rsp_result=0; code 7 with acc=9 -> rsp_err=1, rsp_result=9 (both builds).

Source files
------------

// File: rtl/mesm6_alu_seq_pkg.sv
// mesm6_alu_seq shared constants: ALU micro-op codes, command codes, FSM states.
// Also provides the command-to-micro-op step mapping.
package mesm6_alu_seq_pkg;

  localparam int DW       = 48;
  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_NOP    = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_ADD_CA = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SHIFT  = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_COUNT  = 3'd6;

  localparam logic [2:0] SEQ_CMD_AAX = 3'd0;
  localparam logic [2:0] SEQ_CMD_AOX = 3'd1;
  localparam logic [2:0] SEQ_CMD_AEX = 3'd2;
  localparam logic [2:0] SEQ_CMD_ARX = 3'd3;
  localparam logic [2:0] SEQ_CMD_ASX = 3'd4;
  localparam logic [2:0] SEQ_CMD_ASN = 3'd5;
  localparam logic [2:0] SEQ_CMD_ACX = 3'd6;
  localparam logic [2:0] SEQ_CMD_ILL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_RESP
  } seq_state_e;

  function automatic logic [ALU_OP_W-1:0] step_op(
    input logic [2:0] code,
    input logic       step
  );
    logic [ALU_OP_W-1:0] op;
    op = ALU_NOP;
    unique case (code)
      SEQ_CMD_AAX: op = ALU_AND;
      SEQ_CMD_AOX: op = ALU_OR;
      SEQ_CMD_AEX: op = ALU_XOR;
      SEQ_CMD_ARX: op = ALU_ADD_CA;
      SEQ_CMD_ASX: op = ALU_SHIFT;
      SEQ_CMD_ASN: op = ALU_SHIFT;
      SEQ_CMD_ACX: op = step ? ALU_ADD_CA : ALU_COUNT;
      default:     op = ALU_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mesm6_alu_watchdog.sv
// mesm6_alu_watchdog: counts RUN cycles and flags a stalled ALU micro-op.
// Built only when MESM6_ALU_SEQ_WATCHDOG_EN is defined.
`ifdef MESM6_ALU_SEQ_WATCHDOG_EN
module mesm6_alu_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/mesm6_alu_seq.sv
// mesm6_alu_seq: issues ALU micro-ops per command with a NOP gap between ops.
// Optional RUN timeout abort via MESM6_ALU_SEQ_WATCHDOG_EN.
module mesm6_alu_seq
  import mesm6_alu_seq_pkg::*;
`ifdef MESM6_ALU_SEQ_WATCHDOG_EN
#(
  parameter int TIMEOUT = 15
)
`endif
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_code,
  input  logic [DW-1:0]       cmd_acc,
  input  logic [DW-1:0]       cmd_x,
  input  logic [6:0]          cmd_imm,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [DW-1:0]       alu_result,
  input  logic [DW-1:0]       alu_y,
  input  logic                alu_done,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_result,
  output logic [DW-1:0]       rsp_y,
  output logic                rsp_err
);

  seq_state_e          state_q, state_d;
  logic [2:0]          code_q, code_d;
  logic [DW-1:0]       x_q, x_d;
  logic                step_q, step_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [DW-1:0]       a_q, a_d;
  logic [DW-1:0]       b_q, b_d;
  logic [DW-1:0]       res_q, res_d;
  logic [DW-1:0]       y_q, y_d;
  logic                err_q, err_d;
  logic                wd_expired;

`ifdef MESM6_ALU_SEQ_WATCHDOG_EN
  mesm6_alu_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != ST_RUN),
    .en      (state_q == ST_RUN),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    x_d     = x_q;
    step_d  = step_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    y_d     = y_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          code_d = cmd_code;
          x_d    = cmd_x;
          step_d = 1'b0;
          if (cmd_code == SEQ_CMD_ILL) begin
            res_d   = cmd_acc;
            y_d     = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            op_d    = step_op(cmd_code, 1'b0);
            a_d     = cmd_acc;
            b_d     = (cmd_code == SEQ_CMD_ASN) ?
                      {cmd_imm, 41'b0} : cmd_x;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (alu_done) begin
          res_d   = alu_result;
          y_d     = alu_y;
          op_d    = ALU_NOP;
          state_d = ST_GAP;
        end else if (wd_expired) begin
          res_d   = '0;
          y_d     = '0;
          err_d   = 1'b1;
          op_d    = ALU_NOP;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // ACX chains the count result into an end-around add with X
        if (code_q == SEQ_CMD_ACX && !step_q && !err_q) begin
          step_d  = 1'b1;
          op_d    = step_op(code_q, 1'b1);
          a_d     = res_q;
          b_d     = x_q;
          state_d = ST_RUN;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      x_q     <= '0;
      step_q  <= 1'b0;
      op_q    <= ALU_NOP;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      x_q     <= x_d;
      step_q  <= step_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_result = res_q;
  assign rsp_y      = y_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// tb_mesm6_alu_seq: directed + random commands against a behavioural ALU stub
// and a command-level reference model.
module tb_mesm6_alu_seq;
  import mesm6_alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_code;
  logic [47:0] cmd_acc, cmd_x;
  logic [6:0]  cmd_imm;
  logic [47:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [47:0] alu_result = '0;
  logic [47:0] alu_y = '0;
  logic        alu_done = 1'b0;
  logic        rsp_valid, rsp_ready;
  logic [47:0] rsp_result, rsp_y;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;
  bit stall = 1'b0;
  int stub_cnt = 0;

  mesm6_alu_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_acc(cmd_acc),
    .cmd_x(cmd_x), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_y(alu_y),
    .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_y(rsp_y),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ALU stub: add-carry-around takes 2 cycles, others 1; done sticky until NOP
  function automatic logic [47:0] alu_fn(input logic [2:0] op,
                                         input logic [47:0] a, b);
    logic [48:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_ADD_CA: return s[47:0] + 48'(s[48]);
      ALU_SHIFT:  return b[47] ? (a >> b[46:41]) : (a << b[46:41]);
      ALU_COUNT:  return 48'($countones(a));
      default:    return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_op == ALU_NOP) begin
      stub_cnt <= 0;
      alu_done <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (!stall && stub_cnt + 1 >= ((alu_op == ALU_ADD_CA) ? 2 : 1)) begin
        alu_done   <= 1'b1;
        alu_result <= alu_fn(alu_op, alu_a, alu_b);
        alu_y      <= (alu_op == ALU_XOR) ? alu_a : 48'h0;
      end
    end
  end

  function automatic logic [47:0] end_around(input logic [47:0] a, b);
    logic [48:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[47:0] + 48'(s[48]);
  endfunction

  function automatic void ref_cmd(
    input  logic [2:0]  code,
    input  logic [47:0] acc, x,
    input  logic [6:0]  imm,
    output logic [47:0] r, y,
    output logic        e,
    output int          lat,
    output logic [11:0] seq,
    output int          steps
  );
    y = '0; e = 1'b0; lat = 3; steps = 1;
    case (code)
      3'd0: begin r = acc & x; seq = {6'b0, ALU_AND, ALU_NOP}; end
      3'd1: begin r = acc | x; seq = {6'b0, ALU_OR, ALU_NOP}; end
      3'd2: begin
        r = acc ^ x; y = acc; seq = {6'b0, ALU_XOR, ALU_NOP};
      end
      3'd3: begin
        r = end_around(acc, x); lat = 4;
        seq = {6'b0, ALU_ADD_CA, ALU_NOP};
      end
      3'd4: begin
        r = x[47] ? (acc >> x[46:41]) : (acc << x[46:41]);
        seq = {6'b0, ALU_SHIFT, ALU_NOP};
      end
      3'd5: begin
        r = imm[6] ? (acc >> imm[5:0]) : (acc << imm[5:0]);
        seq = {6'b0, ALU_SHIFT, ALU_NOP};
      end
      3'd6: begin
        r = end_around(48'($countones(acc)), x); lat = 7; steps = 2;
        seq = {ALU_COUNT, ALU_NOP, ALU_ADD_CA, ALU_NOP};
      end
      default: begin
        r = acc; e = 1'b1; lat = -1; steps = 0; seq = '0;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [2:0] code, input logic [47:0] acc, x,
                        input logic [6:0] imm);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_code = code; cmd_acc = acc; cmd_x = x; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_code = 3'($urandom);
    cmd_acc = {16'($urandom), 32'($urandom)};
    cmd_x = {16'($urandom), 32'($urandom)};
    cmd_imm = 7'($urandom);
  endtask

  task automatic wait_rsp(output int lat, output logic [11:0] seq,
                          output int nops);
    logic [2:0] last;
    lat = 0; seq = '0; nops = 0; last = 3'h7;
    while (!rsp_valid && lat < 200) begin
      if (alu_op != last) begin
        seq = {seq[8:0], alu_op};
        last = alu_op;
      end
      if (alu_op == ALU_NOP) nops++;
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
  endtask

  task automatic handshake(input int hold, input logic [47:0] r, y,
                           input logic e);
    repeat (hold) begin
      chk("cmd_ready_in_resp", cmd_ready, 0);
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, r);
      chk("hold_y", rsp_y, y);
      chk("hold_err", rsp_err, e);
    end
    rsp_ready = 1'b1;
    chk("cmd_ready_hs_cycle", cmd_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  task automatic run_cmd(input logic [2:0] code, input logic [47:0] acc, x,
                         input logic [6:0] imm, input int hold,
                         input bit early);
    logic [47:0] r, y;
    logic        e;
    int          elat, steps, lat, nops;
    logic [11:0] eseq, seq;
    ref_cmd(code, acc, x, imm, r, y, e, elat, eseq, steps);
    rsp_ready = early;
    accept(code, acc, x, imm);
    wait_rsp(lat, seq, nops);
    chk("result", rsp_result, r);
    chk("y", rsp_y, y);
    chk("err", rsp_err, e);
    if (steps > 0) begin
      chk("latency", lat, elat);
      chk("op_seq", seq, eseq);
      chk("nop_gap_cycles", nops, steps);
    end
    handshake(early ? 0 : hold, r, y, e);
  endtask

  initial begin
    #200000;
    $display("global time limit reached");
    $fatal(1, "tb_mesm6_alu_seq did not finish");
  end

  initial begin
    logic [47:0] r, y, acc, x;
    logic        e;
    logic [11:0] eseq, seq;
    logic [6:0]  imm;
    logic [2:0]  code;
    int          elat, steps, lat, nops, hold;
    bit          seen, moved, early;

    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_code = '0; cmd_acc = '0; cmd_x = '0; cmd_imm = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_op", alu_op, ALU_NOP);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_y", rsp_y, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    run_cmd(3'd0, 48'hFF00FF, 48'h0F0F0F, 7'h0, 0, 1'b0);
    run_cmd(3'd3, 48'hFFFF_FFFF_FFFF, 48'h1, 7'h0, 1, 1'b0);
    run_cmd(3'd6, 48'h0FF, 48'h5, 7'h0, 0, 1'b0);
    run_cmd(3'd2, 48'h5, 48'h3, 7'h0, 5, 1'b0);
    run_cmd(3'd7, 48'h9, 48'h3, 7'h0, 2, 1'b0);
    run_cmd(3'd1, 48'hA0A0, 48'h0505, 7'h0, 0, 1'b1);

    accept(3'd3, 48'h1234, 48'h1, 7'h0);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_op", alu_op, ALU_NOP);
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_a", alu_a, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    @(negedge clk) reset_n = 1'b1;
    run_cmd(3'd5, 48'h1, 48'h0, 7'h01, 0, 1'b0);
    run_cmd(3'd5, 48'h80, 48'h0, 7'h43, 1, 1'b0);

    stall = 1'b1;
`ifdef MESM6_ALU_SEQ_WATCHDOG_EN
    accept(3'd6, 48'h0FF, 48'h5, 7'h0);
    wait_rsp(lat, seq, nops);
    chk("wd_err", rsp_err, 1);
    chk("wd_result", rsp_result, 0);
    chk("wd_y", rsp_y, 0);
    chk("wd_skip_step", seq, {6'b0, ALU_COUNT, ALU_NOP});
    chk("wd_not_early", lat >= 15, 1);
    handshake(0, 48'h0, 48'h0, 1'b1);
    stall = 1'b0;
`else
    accept(3'd0, 48'h123456, 48'h00FF00, 7'h0);
    seen = 1'b0; moved = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= rsp_valid;
      moved |= (alu_op != ALU_AND);
    end
    chk("stall_no_rsp", seen, 0);
    chk("stall_op_held", moved, 0);
    stall = 1'b0;
    wait_rsp(lat, seq, nops);
    chk("stall_result", rsp_result, 48'h003400);
    chk("stall_err", rsp_err, 0);
    handshake(0, 48'h003400, 48'h0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      code = 3'($urandom_range(0, 7));
      acc = {16'($urandom), 32'($urandom)};
      x = {16'($urandom), 32'($urandom)};
      imm = 7'($urandom);
      if ($urandom_range(0, 1) == 1) x[46:45] = 2'b00;
      if ($urandom_range(0, 1) == 1) imm[5:4] = 2'b00;
      hold = $urandom_range(0, 3);
      early = (hold == 0) && ($urandom_range(0, 1) == 1);
      run_cmd(code, acc, x, imm, hold, early);
    end

    ref_cmd(3'd6, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFD0, 7'h0,
            r, y, e, elat, eseq, steps);
    run_cmd(3'd6, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFD0, 7'h0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
